// File: rtl/load_store_unit_if.sv
// Core request/response and Data_memory port bundle for load_store_unit.
// The LSU uses the slave modport; the core plus memory side uses master.
interface load_store_unit_if #(
  parameter int N = 20
);
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [2:0]   req_funct3;
  logic [31:0]  req_addr;
  logic [31:0]  req_wdata;
  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [31:0]  mem_wd;
  logic [31:0]  mem_rd;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wd
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32 load/store unit in front of a word-wide, synchronous-read data memory.
// Define LSU_MISALIGN_CHECK_EN to flag misaligned/illegal accesses; otherwise alignment is forced.
module load_store_unit #(
  parameter int N = 20,
  parameter int M = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_DATA = 2'd1,
    RMW_MERGE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [N-1:0] word_q;
  logic [1:0]   off_q;
  logic [2:0]   funct3_q;
  logic [15:0]  wdata_q;
  logic         rsp_valid_q;
  logic         rsp_err_q;
  logic [M-1:0] rsp_rdata_q;
  logic         accept;
  logic         req_err;
  logic         req_word;
  logic         mem_we_c;
  logic [N-1:0] mem_addr_c;
  logic [M-1:0] mem_wd_c;
  logic [M-1:0] merged;
  logic [M-1:0] load_ext;
  logic [7:0]   lane_b;
  logic [15:0]  lane_h;
  logic         unused_addr_bits;

  // Address bits above the memory range alias onto the same word.
  assign unused_addr_bits = ^bus.req_addr[31:N+2];
  assign accept   = bus.req_valid && (state == IDLE);
  assign req_word = bus.req_funct3[1];

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    req_err = 1'b0;
    if (bus.req_we) begin
      req_err = bus.req_funct3[2] || (bus.req_funct3 == 3'b011);
    end else begin
      req_err = (bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3 == 3'b110);
    end
    if (req_word && (bus.req_addr[1:0] != 2'b00)) begin
      req_err = 1'b1;
    end
    if ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) begin
      req_err = 1'b1;
    end
  end
`else
  assign req_err = 1'b0;
`endif

  // Lane selection ignores the low offset bits a half/word cannot use, which forces alignment.
  always_comb begin
    lane_b = bus.mem_rd[7:0];
    case (off_q)
      2'd1:    lane_b = bus.mem_rd[15:8];
      2'd2:    lane_b = bus.mem_rd[23:16];
      2'd3:    lane_b = bus.mem_rd[31:24];
      default: lane_b = bus.mem_rd[7:0];
    endcase
    lane_h = off_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
    case (funct3_q[1:0])
      2'b00:   load_ext = {{24{~funct3_q[2] & lane_b[7]}}, lane_b};
      2'b01:   load_ext = {{16{~funct3_q[2] & lane_h[15]}}, lane_h};
      default: load_ext = bus.mem_rd;
    endcase
  end

  always_comb begin
    merged = bus.mem_rd;
    if (funct3_q[1:0] == 2'b00) begin
      case (off_q)
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        2'd3:    merged[31:24] = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  always_comb begin
    state_next = state;
    mem_we_c   = 1'b0;
    mem_addr_c = word_q;
    mem_wd_c   = bus.req_wdata;
    case (state)
      IDLE: begin
        mem_addr_c = bus.req_addr[N+1:2];
        if (accept && !req_err) begin
          if (!bus.req_we) begin
            state_next = LOAD_DATA;
          end else if (req_word) begin
            mem_we_c = 1'b1;
          end else begin
            state_next = RMW_MERGE;
          end
        end
      end
      LOAD_DATA: state_next = IDLE;
      RMW_MERGE: begin
        mem_we_c   = 1'b1;
        mem_wd_c   = merged;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Responses are single-cycle pulses; rdata is nonzero only for completed loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      word_q      <= '0;
      off_q       <= 2'b00;
      funct3_q    <= 3'b000;
      wdata_q     <= 16'h0000;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state       <= state_next;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      if (accept) begin
        word_q   <= bus.req_addr[N+1:2];
        off_q    <= bus.req_addr[1:0];
        funct3_q <= bus.req_funct3;
        wdata_q  <= bus.req_wdata[15:0];
        if (req_err) begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
        end else if (bus.req_we && req_word) begin
          rsp_valid_q <= 1'b1;
        end
      end
      if (state == LOAD_DATA) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= load_ext;
      end
      if (state == RMW_MERGE) begin
        rsp_valid_q <= 1'b1;
      end
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wd    = mem_wd_c;

endmodule
